// File: rtl/regdump_if.sv
// Signal bundle between the register-dump transmitter and its surroundings.
// With REGDUMP_PC_EN defined the bundle also carries the program counter.
interface regdump_if;
  logic        Start;
  logic [4:0]  Regin;
  logic [31:0] Regout;
  logic        Tx;
  logic        Busy;
  logic        Done;
`ifdef REGDUMP_PC_EN
  logic [31:0] PCin;

  modport master (
    output Start, Regout, PCin,
    input  Regin, Tx, Busy, Done
  );

  modport slave (
    input  Start, Regout, PCin,
    output Regin, Tx, Busy, Done
  );
`else
  modport master (
    output Start, Regout,
    input  Regin, Tx, Busy, Done
  );

  modport slave (
    input  Start, Regout,
    output Regin, Tx, Busy, Done
  );
`endif
endinterface

// File: rtl/regdump_tx.sv
// Sweeps the core's register-read port and sends each register as a 5-byte UART record.
// Optional REGDUMP_PC_EN appends one extra record (index byte 8'h20) carrying PCin.
module regdump_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NREGS        = 32
) (
  input  logic      CLOCK,
  input  logic      Reset,
  regdump_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    CAPTURE = 3'd2,
    LOAD    = 3'd3,
    SHIFT   = 3'd4,
    NEXT    = 3'd5,
    FINISH  = 3'd6
  } state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  LAST_IDX = 5'(NREGS - 1);

  state_t      state_q,    state_d;
  logic [4:0]  reg_idx_q,  reg_idx_d;
  logic [31:0] cap_q,      cap_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  bit_idx_q,  bit_idx_d;
  logic [15:0] cnt_q,      cnt_d;
  logic [7:0]  frame_q,    frame_d;
  logic        tx_q,       tx_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
`ifdef REGDUMP_PC_EN
  logic        pc_phase_q, pc_phase_d;
`endif

  logic [7:0]  idx_byte_s;
  logic [7:0]  byte_sel_s;

  // Index byte of the current record; the PC record uses a reserved index.
  always_comb begin
    idx_byte_s = {3'b000, reg_idx_q};
`ifdef REGDUMP_PC_EN
    if (pc_phase_q) begin
      idx_byte_s = 8'h20;
    end else begin
      idx_byte_s = {3'b000, reg_idx_q};
    end
`endif
  end

  // Record byte selected by byte_idx: index first, then data MSB to LSB.
  always_comb begin
    byte_sel_s = 8'h00;
    case (byte_idx_q)
      3'd0:    byte_sel_s = idx_byte_s;
      3'd1:    byte_sel_s = cap_q[31:24];
      3'd2:    byte_sel_s = cap_q[23:16];
      3'd3:    byte_sel_s = cap_q[15:8];
      3'd4:    byte_sel_s = cap_q[7:0];
      default: byte_sel_s = 8'h00;
    endcase
  end

  // Next-state and datapath logic for the dump sequencer.
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    cap_d      = cap_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef REGDUMP_PC_EN
    pc_phase_d = pc_phase_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          reg_idx_d  = 5'd0;
          busy_d     = 1'b1;
          state_d    = SELECT;
`ifdef REGDUMP_PC_EN
          pc_phase_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      SELECT: begin
        state_d = CAPTURE;
      end

      CAPTURE: begin
        cap_d      = bus.Regout;
        byte_idx_d = 3'd0;
        state_d    = LOAD;
      end

      // For bytes after the first, the start bit already began on the previous
      // stop-bit edge, so this cycle counts as its first bit-time cycle.
      LOAD: begin
        frame_d   = byte_sel_s;
        tx_d      = 1'b0;
        bit_idx_d = 4'd0;
        if (byte_idx_q == 3'd0) begin
          cnt_d = 16'd0;
        end else begin
          cnt_d = 16'd1;
        end
        state_d = SHIFT;
      end

      SHIFT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = 16'd0;
          if (bit_idx_q == 4'd9) begin
            if (byte_idx_q < 3'd4) begin
              byte_idx_d = byte_idx_q + 3'd1;
              tx_d       = 1'b0;
              state_d    = LOAD;
            end else begin
              tx_d    = 1'b1;
              state_d = NEXT;
            end
          end else begin
            // Shifting in ones leaves the stop bit at frame_q[0] after the data.
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = frame_q[0];
            frame_d   = {1'b1, frame_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      NEXT: begin
`ifdef REGDUMP_PC_EN
        if (pc_phase_q) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (reg_idx_q == LAST_IDX) begin
          pc_phase_d = 1'b1;
          cap_d      = bus.PCin;
          byte_idx_d = 3'd0;
          state_d    = LOAD;
        end else begin
          reg_idx_d = reg_idx_q + 5'd1;
          state_d   = SELECT;
        end
`else
        if (reg_idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          reg_idx_d = reg_idx_q + 5'd1;
          state_d   = SELECT;
        end
`endif
      end

      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      reg_idx_q  <= 5'd0;
      cap_q      <= 32'd0;
      byte_idx_q <= 3'd0;
      bit_idx_q  <= 4'd0;
      cnt_q      <= 16'd0;
      frame_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef REGDUMP_PC_EN
      pc_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      cap_q      <= cap_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef REGDUMP_PC_EN
      pc_phase_q <= pc_phase_d;
`endif
    end
  end

  assign bus.Regin = reg_idx_q;
  assign bus.Tx    = tx_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_regdump_tx.sv
// Directed bench for regdump_tx: full 32-register dump plus a single-register instance.
module tb_regdump_tx;

  localparam int CPB = 4;
`ifdef REGDUMP_PC_EN
  localparam int EXP_BYTES  = 165;
  localparam int EXP_CYC    = 6730;
  localparam int EXP1_BYTES = 10;
  localparam int EXP1_CYC   = 406;
`else
  localparam int EXP_BYTES  = 160;
  localparam int EXP_CYC    = 6528;
  localparam int EXP1_BYTES = 5;
  localparam int EXP1_CYC   = 204;
`endif

  logic CLOCK;
  logic Reset;
  bit   ovr;

  regdump_if bus ();
  regdump_if bus1 ();

  regdump_tx #(.CLKS_PER_BIT(CPB), .NREGS(32)) dut (
    .CLOCK (CLOCK),
    .Reset (Reset),
    .bus   (bus)
  );

  regdump_tx #(.CLKS_PER_BIT(CPB), .NREGS(1)) dut1 (
    .CLOCK (CLOCK),
    .Reset (Reset),
    .bus   (bus1)
  );

  // Core register-file model: each register reads back 0xA50000nn.
  assign bus.Regout  = ovr ? 32'hFFFFFFFF : (32'hA5000000 | {27'd0, bus.Regin});
  assign bus1.Regout = 32'hA5000000 | {27'd0, bus1.Regin};
`ifdef REGDUMP_PC_EN
  assign bus.PCin  = 32'h00400010;
  assign bus1.PCin = 32'h00400010;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int ferr        = 0;
  logic [7:0] rx[$];

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    forever begin
      @(posedge CLOCK);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge CLOCK);
      if (bus.Done === 1'b1) done_cnt++;
    end
  end

  // Background UART receiver on the main instance, sampling mid-bit.
  initial begin
    bit         act;
    int         rc;
    int         k;
    logic [7:0] sh;
    act = 1'b0;
    rc  = 0;
    sh  = 8'h00;
    forever begin
      @(negedge CLOCK);
      if (Reset !== 1'b1) begin
        act = 1'b0;
      end else if (!act) begin
        if (bus.Tx === 1'b0) begin
          act = 1'b1;
          rc  = 0;
        end
      end else begin
        rc++;
        if (rc % CPB == CPB / 2) begin
          k = rc / CPB;
          if (k == 0 && bus.Tx !== 1'b0) ferr++;
          if (k >= 1 && k <= 8) sh[k-1] = bus.Tx;
          if (k == 9) begin
            if (bus.Tx !== 1'b1) ferr++;
            rx.push_back(sh);
            act = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int i, input int nregs);
    int rec;
    int b;
    rec = i / 5;
    b   = i % 5;
    if (rec == nregs) begin
      case (b)
        0:       return 8'h20;
        2:       return 8'h40;
        4:       return 8'h10;
        default: return 8'h00;
      endcase
    end else begin
      case (b)
        0, 4:    return 8'(rec);
        1:       return 8'hA5;
        default: return 8'h00;
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_regin(input logic [4:0] v);
    for (int n = 0; n < 10000; n++) begin
      @(posedge CLOCK);
      #1;
      if (bus.Regin == v) break;
    end
    chk("wait_regin", {27'd0, bus.Regin}, {27'd0, v});
  endtask

  // Decode one byte from the single-register instance, waiting for its start bit.
  task automatic rx_byte1(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int n = 0; n < 600; n++) begin
      @(negedge CLOCK);
      if (bus1.Tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (CPB / 2) @(negedge CLOCK);
      if (bus1.Tx !== 1'b0) ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge CLOCK);
        b[j] = bus1.Tx;
      end
      repeat (CPB) @(negedge CLOCK);
      if (bus1.Tx !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin
    int         start_cyc;
    int         dcyc;
    int         lows;
    int         nchk;
    bit         ok;
    logic [7:0] b;

    Reset     = 1'b0;
    ovr       = 1'b0;
    bus.Start  = 1'b0;
    bus1.Start = 1'b0;

    // Reset state
    repeat (2) @(negedge CLOCK);
    chk("rst_tx",    {31'd0, bus.Tx},   32'd1);
    chk("rst_busy",  {31'd0, bus.Busy}, 32'd0);
    chk("rst_done",  {31'd0, bus.Done}, 32'd0);
    chk("rst_regin", {27'd0, bus.Regin}, 32'd0);
    Reset = 1'b1;
    repeat (3) @(negedge CLOCK);
    chk("idle_busy", {31'd0, bus.Busy}, 32'd0);

    // Start accepted; check first-frame latency
    bus.Start = 1'b1;
    @(posedge CLOCK);
    #1;
    start_cyc = cyc;
    bus.Start = 1'b0;
    chk("acc_busy",  {31'd0, bus.Busy}, 32'd1);
    chk("acc_regin", {27'd0, bus.Regin}, 32'd0);
    chk("acc_tx",    {31'd0, bus.Tx},   32'd1);
    @(posedge CLOCK);
    #1;
    chk("t1_tx", {31'd0, bus.Tx}, 32'd1);
    @(posedge CLOCK);
    #1;
    chk("t2_tx", {31'd0, bus.Tx}, 32'd1);
    @(posedge CLOCK);
    #1;
    chk("t3_start_bit", {31'd0, bus.Tx}, 32'd0);

    // Corrupt Regout after register 3 is captured
    wait_regin(5'd3);
    repeat (2) @(posedge CLOCK);
    #1;
    ovr = 1'b1;
    repeat (40) @(posedge CLOCK);
    #1;
    ovr = 1'b0;

    // Start pulse mid-dump must be ignored
    wait_regin(5'd16);
    bus.Start = 1'b1;
    @(posedge CLOCK);
    #1;
    bus.Start = 1'b0;
    chk("mid_busy", {31'd0, bus.Busy}, 32'd1);

    for (int n = 0; n < 10000; n++) begin
      @(negedge CLOCK);
      if (bus.Done === 1'b1) break;
    end
    dcyc = cyc - start_cyc;
    chk("done_seen",  {31'd0, bus.Done}, 32'd1);
    chk("done_cycle", 32'(dcyc), 32'(EXP_CYC));
    chk("busy_at_done", {31'd0, bus.Busy}, 32'd1);
    @(negedge CLOCK);
    chk("done_pulse_end", {31'd0, bus.Done}, 32'd0);
    chk("busy_after_done", {31'd0, bus.Busy}, 32'd0);
    repeat (40) @(negedge CLOCK);
    chk("done_count",  32'(done_cnt), 32'd1);
    chk("byte_count",  32'(rx.size()), 32'(EXP_BYTES));
    chk("frame_errors", 32'(ferr), 32'd0);
    chk("no_restart", {31'd0, bus.Busy}, 32'd0);
    nchk = (rx.size() < EXP_BYTES) ? rx.size() : EXP_BYTES;
    for (int i = 0; i < nchk; i++) begin
      chk($sformatf("byte%0d", i), {24'd0, rx[i]}, {24'd0, exp_byte(i, 32)});
    end

    // Reset in the middle of a frame
    bus.Start = 1'b1;
    @(posedge CLOCK);
    #1;
    bus.Start = 1'b0;
    repeat (100) @(posedge CLOCK);
    #1;
    chk("pre_rst_busy", {31'd0, bus.Busy}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("async_tx",    {31'd0, bus.Tx},   32'd1);
    chk("async_busy",  {31'd0, bus.Busy}, 32'd0);
    chk("async_done",  {31'd0, bus.Done}, 32'd0);
    chk("async_regin", {27'd0, bus.Regin}, 32'd0);
    repeat (3) @(negedge CLOCK);
    Reset = 1'b1;
    lows = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge CLOCK);
      if (bus.Tx !== 1'b1) lows++;
    end
    chk("quiet_after_rst", 32'(lows), 32'd0);
    chk("busy_after_rst",  {31'd0, bus.Busy}, 32'd0);

    // Single-register instance
    @(negedge CLOCK);
    bus1.Start = 1'b1;
    @(posedge CLOCK);
    #1;
    start_cyc  = cyc;
    bus1.Start = 1'b0;
    for (int i = 0; i < EXP1_BYTES; i++) begin
      rx_byte1(b, ok);
      chk($sformatf("n1_frame%0d", i), {31'd0, ok}, 32'd1);
      chk($sformatf("n1_byte%0d", i), {24'd0, b}, {24'd0, exp_byte(i, 1)});
    end
    for (int n = 0; n < 500; n++) begin
      @(negedge CLOCK);
      if (bus1.Done === 1'b1) break;
    end
    dcyc = cyc - start_cyc;
    chk("n1_done_seen",  {31'd0, bus1.Done}, 32'd1);
    chk("n1_done_cycle", 32'(dcyc), 32'(EXP1_CYC));
    @(negedge CLOCK);
    chk("n1_busy_after", {31'd0, bus1.Busy}, 32'd0);
    chk("n1_tx_idle",    {31'd0, bus1.Tx},   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regdump_tx.md
# regdump_tx

Register-file dump transmitter for the multicycle RISC-V core's debug read port. On a start pulse it sweeps the register-select index 0..31, captures each 32-bit register value from the core's register-read output, and serializes it over a UART TX line (8N1, LSB first). It sits beside the processor in the top level and replaces manual switch-driven register inspection with a host-readable stream.

## Interface
Parameters:
- CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- NREGS, default 32, number of registers swept; legal range 1..32.

Ports:
- CLOCK  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request a dump; sampled only in IDLE.
- Regin  out  5  register-select index driven to the core's register-read port.
- Regout  in  32  register value returned by the core; combinational from Regin.
- Tx  out  1  UART serial output; idles high.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: Tx=1, Regin=0, Busy=0, Done=0, FSM=IDLE, all counters 0.
- FSM states: IDLE, SELECT, CAPTURE, LOAD, SHIFT, NEXT, FINISH.
- IDLE: Start=1 -> Regin<=0, reg index<=0, go SELECT. Start=0 -> remain in IDLE.
- SELECT: Regin holds the index for one settle cycle -> CAPTURE.
- CAPTURE: latch Regout into a 32-bit capture register, set byte index=0 -> LOAD.
- LOAD: select the next byte of the record -> SHIFT. Record is 5 bytes: {3'b000, index[4:0]}, then data[31:24], [23:16], [15:8], [7:0].
- SHIFT: emit start bit (0), 8 data bits LSB first, stop bit (1), each held CLKS_PER_BIT cycles. After the stop bit, if byte index<4, increment it -> LOAD; else -> NEXT.
- NEXT: if index==NREGS-1 -> FINISH; else index+1 -> Regin, go SELECT.
- FINISH: Done=1 for one cycle, Busy<=0 -> IDLE.
- Start while Busy is ignored; no queuing. Start held high through FINISH launches a new dump on the first IDLE cycle.
- Regout changes while a byte is shifting do not affect the frame; only the CAPTURE value is sent.

## Timing
- Start sampled at edge t -> Regin=0 and Busy=1 after t; capture at t+2; start bit begins at t+3.
- Back-to-back bytes within a record: no idle gap; stop bit is followed directly by the next start bit. Between records, Tx stays high for 3 cycles (NEXT, SELECT, CAPTURE) plus 1 LOAD cycle.
- Byte time is 10*CLKS_PER_BIT cycles. Bit counter wraps at CLKS_PER_BIT-1.
- Done follows the final stop bit's last cycle by one edge.
- Reset asserted mid-frame: Tx=1, Busy=0 immediately (async). The partial byte is abandoned, and the host sees a framing gap.

## Configuration
- REGDUMP_PC_EN defined: adds input PCin [31:0]. After register NREGS-1, one extra record is sent with index byte 8'h20 and the PCin value captured in the cycle after the last register record ends. Done pulses after this record.
- Undefined: no PCin port; exactly NREGS records are sent.

## Test plan
- Reset: Reset=0 mid-operation -> Tx=1, Busy=0, Done=0, Regin=0 within the same cycle; no further Tx transitions until Start.
- Single dump with CLKS_PER_BIT=4 and a model returning Regout=32'hA5000000|Regin: decoded stream is 160 bytes, with record 7 = 07 A5 00 00 07. Done pulses once, 6400+ cycles after Start.
- Capture stability: Regout changes to 32'hFFFFFFFF during the SHIFT of register 3 -> record 3 still carries the value sampled at CAPTURE.
- Start ignored while busy: pulse Start at mid-dump -> exactly one Done and 160 bytes; a second dump starts only after a later Start.
- NREGS=1: Start -> one 5-byte record (index 00), Busy low right after Done.
- REGDUMP_PC_EN with PCin=32'h00400010 -> final record is 20 00 40 00 10; total 165 bytes.
